// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule.
// Loads the cipher key and runs the forward schedule up to the round-10 key.
// It then steps the schedule backwards and presents round keys 10 down to 0,
// one key per valid/ready transfer, for the inverse-cipher round controller.
//
// Ports
//   CLK, RST               clock; synchronous active-high reset
//   start_in               load key*_in and begin (sampled only while idle)
//   key0_in..key3_in       cipher key words (key0_in[31:24] = first key byte)
//   ready_in               consumer takes the presented round key
//   key0_out..key3_out     round key words (0 when valid_out is low)
//   round_out              round index of the presented key (10..0)
//   valid_out              key*_out / round_out are valid
//   busy_out               high whenever the block is not idle
//   done_out               pulse on the transfer of round key 0
//
// Helper blocks in this file: aes_sbox (byte S-box), aes_sub_word (SubWord),
// aes_rot_word (RotWord).

module aes_sbox (
  input  logic [7:0] in_b,
  output logic [7:0] out_b
);
  // Index 0 is the leftmost (most significant) byte of the constant.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_b = SBOX[in_b];
endmodule

module aes_sub_word (
  input  logic [31:0] w_in,
  output logic [31:0] w_out
);
  // One S-box per byte lane.
  aes_sbox u_sbox [3:0] (
    .in_b  (w_in),
    .out_b (w_out)
  );
endmodule

module aes_rot_word (
  input  logic [31:0] w_in,
  output logic [31:0] w_out
);
  assign w_out = {w_in[23:0], w_in[31:24]};
endmodule

module aes_inv_key_schedule #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_in,
  input  logic [31:0] key0_in,
  input  logic [31:0] key1_in,
  input  logic [31:0] key2_in,
  input  logic [31:0] key3_in,
  input  logic        ready_in,
  output logic [31:0] key0_out,
  output logic [31:0] key1_out,
  output logic [31:0] key2_out,
  output logic [31:0] key3_out,
  output logic [3:0]  round_out,
  output logic        valid_out,
  output logic        busy_out,
  output logic        done_out
);
  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_inv_key_schedule supports only NUM_ROUNDS = 10");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        round_q, round_d;
  logic [3:0][31:0]  w_q, w_d;   // w_q[0] is key word 0

  logic [31:0] rot_in, rot_out, sub_out;
  logic [31:0] t, n0, n1, n2, n3;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Single shared S-box word path. Going backwards, the word fed to
  // SubWord is the recovered w3 of the previous round, which is w3^w2.
  assign rot_in = (state_q == EMIT) ? (w_q[3] ^ w_q[2]) : w_q[3];

  aes_rot_word u_rot (.w_in(rot_in),  .w_out(rot_out));
  aes_sub_word u_sub (.w_in(rot_out), .w_out(sub_out));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    w_d     = w_q;
    t       = 32'h0;
    n0      = 32'h0;
    n1      = 32'h0;
    n2      = 32'h0;
    n3      = 32'h0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          w_d     = {key3_in, key2_in, key1_in, key0_in};
          cnt_d   = 4'd0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        t     = sub_out ^ {rcon(cnt_q + 4'd1), 24'h0};
        n0    = w_q[0] ^ t;
        n1    = w_q[1] ^ n0;
        n2    = w_q[2] ^ n1;
        n3    = w_q[3] ^ n2;
        w_d   = {n3, n2, n1, n0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_RND - 4'd1) begin
          state_d = EMIT;
          round_d = LAST_RND;
        end
      end
      EMIT: begin
        if (ready_in) begin
          if (round_q != 4'd0) begin
            n3      = w_q[3] ^ w_q[2];
            n2      = w_q[2] ^ w_q[1];
            n1      = w_q[1] ^ w_q[0];
            n0      = w_q[0] ^ sub_out ^ {rcon(round_q), 24'h0};
            w_d     = {n3, n2, n1, n0};
            round_d = round_q - 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      round_q <= 4'd0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      w_q     <= w_d;
    end
  end

  // Outputs decode registered state; done_out follows ready_in in the
  // transfer cycle itself.
  assign valid_out = (state_q == EMIT);
  assign key0_out  = valid_out ? w_q[0]  : 32'h0;
  assign key1_out  = valid_out ? w_q[1]  : 32'h0;
  assign key2_out  = valid_out ? w_q[2]  : 32'h0;
  assign key3_out  = valid_out ? w_q[3]  : 32'h0;
  assign round_out = valid_out ? round_q : 4'd0;
  assign busy_out  = (state_q != IDLE);
  assign done_out  = valid_out & ready_in & (round_q == 4'd0);
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
module tb_aes_inv_key_schedule;
  logic        CLK = 1'b0;
  logic        RST;
  logic        start_in;
  logic [31:0] key0_in, key1_in, key2_in, key3_in;
  logic        ready_in;
  logic [31:0] key0_out, key1_out, key2_out, key3_out;
  logic [3:0]  round_out;
  logic        valid_out, busy_out, done_out;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] cap_r10, cap_r9, cap_r0;

  aes_inv_key_schedule #(.NUM_ROUNDS(10)) dut (
    .CLK(CLK), .RST(RST), .start_in(start_in),
    .key0_in(key0_in), .key1_in(key1_in), .key2_in(key2_in), .key3_in(key3_in),
    .ready_in(ready_in),
    .key0_out(key0_out), .key1_out(key1_out), .key2_out(key2_out), .key3_out(key3_out),
    .round_out(round_out), .valid_out(valid_out), .busy_out(busy_out), .done_out(done_out)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500us;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference S-box from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h0;
      logic [7:0] p   = 8'h01;
      if (x != 0) begin
        for (int k = 0; k < 254; k++) p = gmul(p, 8'(x));
        inv = p;
      end
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Forward KeyExpansion; result[r] = {w0,w1,w2,w3} of round r.
  function automatic logic [10:0][127:0] expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [7:0]  rc [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [10:0][127:0] rk;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp ^= {rc[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  function automatic logic [127:0] outs();
    return {key0_out, key1_out, key2_out, key3_out};
  endfunction

  // mode 0: ready high; 1: random ready; 2: start held and key inputs scrambled.
  // Issues start in the next cycle and returns after the done cycle.
  task automatic run_burst(input logic [127:0] key, input int mode);
    logic [10:0][127:0] rk = expand(key);
    int exp_r = 10, first = -1, dones = 0;
    bit fin = 0, hold = 0;
    logic [131:0] saved = '0;
    @(posedge CLK); #1;
    start_in = 1'b1;
    {key0_in, key1_in, key2_in, key3_in} = key;
    ready_in = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    chk("idle_busy", busy_out, 0);
    chk("idle_valid", valid_out, 0);
    for (int i = 1; i <= 60 && !fin; i++) begin
      @(posedge CLK); #1;
      start_in = (mode == 2);
      if (mode == 2) {key0_in, key1_in, key2_in, key3_in} = {$urandom, $urandom, $urandom, $urandom};
      ready_in = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (hold) begin
        chk("hold_valid", valid_out, 1);
        chk("hold_data", {round_out, outs()}, saved);
      end
      if (valid_out) begin
        if (first < 0) begin
          first = i;
          chk("latency", i, 11);
        end
        chk("round", round_out, exp_r);
        chk($sformatf("key_r%0d", exp_r), outs(), rk[exp_r]);
        chk("busy_emit", busy_out, 1);
        chk("done", done_out, (ready_in && exp_r == 0));
        if (done_out) dones++;
        if (exp_r == 10) cap_r10 = outs();
        if (exp_r == 9)  cap_r9  = outs();
        if (exp_r == 0)  cap_r0  = outs();
        hold = !ready_in;
        saved = {round_out, outs()};
        if (ready_in) begin
          if (exp_r == 0) fin = 1;
          else exp_r--;
        end
      end else begin
        if (done_out) dones++;
        if (first >= 0) chk("valid_drop", valid_out, 1);
        else if (i < 11) chk("busy_expand", {busy_out, round_out, outs()}, {1'b1, 132'h0});
      end
    end
    chk("burst_end", fin, 1);
    chk("done_count", dones, 1);
  endtask

  initial begin
    logic [127:0] k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] k2 = 128'h000102030405060708090a0b0c0d0e0f;
    bit hit;
    build_sbox();
    RST = 1'b1; start_in = 1'b0; ready_in = 1'b0;
    {key0_in, key1_in, key2_in, key3_in} = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_keys", outs(), 0);
    chk("rst_round", round_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    RST = 1'b0;

    // Scenario 1: ready held high, directed FIPS-197 values.
    run_burst(k1, 0);
    chk("fips_r10", cap_r10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_r9",  cap_r9,  128'hac7766f319fadc2128d12941575c006e);
    chk("fips_r0",  cap_r0,  k1);

    // Scenario 2: back-to-back start, random ready.
    run_burst(k1, 1);
    // Scenario 3: start held and key inputs scrambled mid-operation.
    run_burst(k1, 2);
    chk("fips_r10_scr", cap_r10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    @(posedge CLK); #1;
    start_in = 1'b0;
    #1;
    chk("post_done_idle", busy_out, 0);

    // Scenario 4: reset while round 5 is presented.
    @(posedge CLK); #1;
    start_in = 1'b1; {key0_in, key1_in, key2_in, key3_in} = k1; ready_in = 1'b1;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge CLK); #1;
      start_in = 1'b0;
      #1;
      if (valid_out && round_out == 4'd5) hit = 1;
    end
    chk("reach_r5", hit, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    #1;
    chk("midrst_out", {valid_out, busy_out, done_out, round_out, outs()}, 135'h0);
    repeat (3) @(posedge CLK);
    #1;
    chk("midrst_stay", {valid_out, busy_out}, 2'b00);
    run_burst(k2, 0);
    chk("k2_r10", cap_r10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Scenario 6: random keys against the forward expansion, back to back.
    for (int n = 0; n < 100; n++)
      run_burst({$urandom, $urandom, $urandom, $urandom}, n % 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
